// File: rtl/nvme_ctrl_state_if.sv
// Register-file <-> enable/shutdown sequencer bundle.
// master = register file side, slave = sequencer side.
interface nvme_ctrl_state_if;
  logic [31:0] cc;
  logic        qengine_idle;
  logic        fatal_err;
  logic [31:0] csts;
  logic        ctrl_enabled;
  logic        ctrl_reset_req;

  modport master (
    output cc,
    output qengine_idle,
    output fatal_err,
    input  csts,
    input  ctrl_enabled,
    input  ctrl_reset_req
  );

  modport slave (
    input  cc,
    input  qengine_idle,
    input  fatal_err,
    output csts,
    output ctrl_enabled,
    output ctrl_reset_req
  );
endinterface

// File: rtl/nvme_ctrl_state.sv
// NVMe controller enable/shutdown sequencer.
// Tracks CC.EN / CC.SHN and produces CSTS plus queue-engine gating.
module nvme_ctrl_state #(
  parameter int EN_DELAY  = 16,
  parameter int DIS_DELAY = 8,
  parameter int SHN_DELAY = 32,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             reset_n,
  nvme_ctrl_state_if.slave bus
);

  localparam logic [2:0] S_DIS  = 3'd0;
  localparam logic [2:0] S_ENA  = 3'd1;
  localparam logic [2:0] S_RDY  = 3'd2;
  localparam logic [2:0] S_SHD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_DSG  = 3'd5;

  localparam logic [CNT_W-1:0] EN_LD  = CNT_W'(EN_DELAY - 1);
  localparam logic [CNT_W-1:0] DIS_LD = CNT_W'(DIS_DELAY - 1);
  localparam logic [CNT_W-1:0] SHN_LD = CNT_W'(SHN_DELAY - 1);

  logic [2:0]       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             rdy_q, rdy_n;
  logic             cfs_q, cfs_n;
  logic [1:0]       shst_q, shst_n;
  logic             en_q, en_n;
  logic             req_q, req_n;

  logic       en;
  logic [1:0] shn;
  logic       cnt_zero;
  logic       unused;

  assign en       = bus.cc[0];
  assign shn      = bus.cc[15:14];
  assign cnt_zero = (cnt_q == '0);
  assign unused   = ^{bus.cc[31:16], bus.cc[13:1]};

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_DIS: begin
        if (en) begin
          state_n = S_ENA;
          cnt_n   = EN_LD;
        end
      end
      S_ENA: begin
        if (!en) begin
          state_n = S_DSG;
          cnt_n   = DIS_LD;
        end else if (cnt_zero) begin
          state_n = S_RDY;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_RDY: begin
        if (!en) begin
          state_n = S_DSG;
          cnt_n   = DIS_LD;
        end else if (shn != 2'b00) begin
          state_n = S_SHD;
          cnt_n   = SHN_LD;
        end
      end
      S_SHD: begin
        if (!en) begin
          state_n = S_DSG;
          cnt_n   = DIS_LD;
        end else if (cnt_zero && bus.qengine_idle) begin
          state_n = S_DONE;
        end else if (!cnt_zero) begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (!en) begin
          state_n = S_DSG;
          cnt_n   = DIS_LD;
        end
      end
      S_DSG: begin
        if (cnt_zero) begin
          state_n = S_DIS;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: begin
        state_n = S_DIS;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs derive from the next state so they land with the transition.
  always_comb begin
    rdy_n  = rdy_q;
    cfs_n  = cfs_q;
    shst_n = shst_q;
    en_n   = (state_n == S_RDY);
    req_n  = (state_n == S_DSG) && (state_q != S_DSG);
    unique case (1'b1)
      (state_n == S_DIS): begin
        rdy_n  = 1'b0;
        shst_n = 2'b00;
      end
      (state_n == S_RDY):  rdy_n  = 1'b1;
      (state_n == S_SHD):  shst_n = 2'b01;
      (state_n == S_DONE): shst_n = 2'b10;
      default: ;
    endcase
    if (state_n == S_DIS) begin
      cfs_n = 1'b0;
    end else if (bus.fatal_err && state_q != S_DIS &&
                 state_q != S_DSG && state_n != S_DSG) begin
      cfs_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_DIS;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      cfs_q   <= 1'b0;
      shst_q  <= 2'b00;
      en_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rdy_q   <= rdy_n;
      cfs_q   <= cfs_n;
      shst_q  <= shst_n;
      en_q    <= en_n;
      req_q   <= req_n;
    end
  end

  assign bus.csts           = {28'd0, shst_q, cfs_q, rdy_q};
  assign bus.ctrl_enabled   = en_q;
  assign bus.ctrl_reset_req = req_q;

endmodule
